// File: rtl/fp_mult_pkg.sv
// Shared types for the FP multiplier result collector: status flag indices,
// collector FSM states and the buffered result record.
package fp_mult_pkg;

    localparam int ST_ZERO    = 0;
    localparam int ST_INF     = 1;
    localparam int ST_NAN     = 2;
    localparam int ST_TINY    = 3;
    localparam int ST_HUGE    = 4;
    localparam int ST_INEXACT = 5;
    localparam int NUM_FLAGS  = 6;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] z;
        logic [7:0]  status;
    } result_t;

endpackage

// File: rtl/fp_result_fifo.sv
// Result storage for the collector: circular buffer with read/write pointers
// and an occupancy count. push/pop arrive already qualified by the top.
module fp_result_fifo
    import fp_mult_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  result_t                wdata,
    output result_t                rdata,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    result_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fp_mult_result_collector.sv
// Buffers multiplier results in a FWFT FIFO and counts status flags on push.
// Flag counters are built only when FP_MULT_STAT_COUNT_EN is defined.
module fp_mult_result_collector
    import fp_mult_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [31:0]                z,
    input  logic [7:0]                 status,
    output logic                       in_ready,
    input  logic                       flush,
    input  logic                       clr_cnt,
    output logic                       out_valid,
    output logic [31:0]                out_z,
    output logic [7:0]                 out_status,
    input  logic                       out_ready,
    output logic [NUM_FLAGS*CNT_W-1:0] cnt,
    output logic [$clog2(DEPTH):0]     level,
    output state_t                     fsm_state
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(DEPTH - 1);

    state_t  state_q, state_d;
    result_t head;
    logic    push, pop;

    // Handshake: a transfer happens on a cycle where valid and ready are both
    // high; ready never depends on valid on either side.
    assign in_ready  = rst && (state_q != FULL) && !flush;
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    fp_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ('{z: z, status: status}),
        .rdata (head),
        .level (level)
    );

    assign out_z      = out_valid ? head.z : '0;
    assign out_status = out_valid ? head.status : '0;
    assign fsm_state  = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= EMPTY;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (push && !pop) begin
            state_d = (level == LVL_LAST) ? FULL : PARTIAL;
        end else if (pop && !push) begin
            state_d = (level == LVL_ONE) ? EMPTY : PARTIAL;
        end
    end

`ifdef FP_MULT_STAT_COUNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_FLAGS];

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_FLAGS; i++) cnt_q[i] <= '0;
        end else if (clr_cnt) begin
            for (int i = 0; i < NUM_FLAGS; i++) cnt_q[i] <= '0;
        end else if (push) begin
            for (int i = 0; i < NUM_FLAGS; i++) begin
                if (status[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_FLAGS; g++) begin : g_cnt
        assign cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`else
    logic unused_clr;
    assign unused_clr = clr_cnt;
    assign cnt        = '0;
`endif

endmodule
